// File: rtl/prime_factorizer.sv
// prime_factorizer: emits the prime factors of an unsigned number in ascending
// order, one per factor_valid/factor_ack handshake, using trial division by
// 2, 3, 5, 7, 9, ... and a restoring shift-subtract divider.
// Optional build macro PRIME_FACTORIZER_MULT_EN: adds a 'mult' output and
// emits each distinct prime once together with its multiplicity.
module prime_factorizer #(
  parameter int  WIDTH_LOG = 4,
  localparam int WIDTH     = 1 << WIDTH_LOG
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  input  logic [WIDTH-1:0]   num,
  output logic               ready,
  output logic               error,
  output logic [WIDTH-1:0]   factor,
  output logic               factor_valid,
`ifdef PRIME_FACTORIZER_MULT_EN
  output logic [WIDTH_LOG:0] mult,
`endif
  input  logic               factor_ack
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ERR      = 3'd1,
    S_CHECK    = 3'd2,
    S_DIV      = 3'd3,
    S_RESULT   = 3'd4,
    S_EMIT     = 3'd5,
    S_LAST     = 3'd6,
    S_LAST_ACK = 3'd7
  } state_t;

  state_t               state_r, state_nxt;
  logic [WIDTH-1:0]     n_r, n_nxt;
  logic [WIDTH-1:0]     d_r, d_nxt;
  logic [2*WIDTH-1:0]   d_sq_r, d_sq_nxt;
  logic [WIDTH-1:0]     q_r, q_nxt;
  logic [WIDTH-1:0]     r_r, r_nxt;
  logic [WIDTH_LOG:0]   cnt_r, cnt_nxt;
  logic [WIDTH-1:0]     factor_r, factor_nxt;
  logic                 factor_valid_r, factor_valid_nxt;
  logic                 ready_r, ready_nxt;
  logic                 error_r, error_nxt;
`ifdef PRIME_FACTORIZER_MULT_EN
  logic [WIDTH_LOG:0]   mult_r, mult_nxt;
  logic [WIDTH_LOG:0]   mcnt_r, mcnt_nxt;
`endif

  logic [WIDTH:0]       rem_shift_s;
  logic [WIDTH:0]       diff_s;
  logic [WIDTH-1:0]     d_adv_s;
  logic [2*WIDTH-1:0]   d_sq_adv_s;

  assign ready        = ready_r;
  assign error        = error_r;
  assign factor       = factor_r;
  assign factor_valid = factor_valid_r;
`ifdef PRIME_FACTORIZER_MULT_EN
  assign mult         = mult_r;
`endif

  // Next-state, datapath and registered-output computation for the factoring FSM.
  always_comb begin
    state_nxt        = state_r;
    n_nxt            = n_r;
    d_nxt            = d_r;
    d_sq_nxt         = d_sq_r;
    q_nxt            = q_r;
    r_nxt            = r_r;
    cnt_nxt          = cnt_r;
    factor_nxt       = factor_r;
    factor_valid_nxt = factor_valid_r;
`ifdef PRIME_FACTORIZER_MULT_EN
    mult_nxt         = mult_r;
    mcnt_nxt         = mcnt_r;
`endif

    // One restoring-divider step: the sign bit of diff_s says whether d fits.
    rem_shift_s = {r_r, q_r[WIDTH-1]};
    diff_s      = rem_shift_s - {1'b0, d_r};

    // Next trial divisor; d_sq follows as (d+2)^2 = d^2 + 4d + 4.
    if (d_r == WIDTH'(2'd2)) begin
      d_adv_s    = WIDTH'(2'd3);
      d_sq_adv_s = (2*WIDTH)'(4'd9);
    end else begin
      d_adv_s    = d_r + WIDTH'(2'd2);
      d_sq_adv_s = d_sq_r + {{(WIDTH-2){1'b0}}, d_r, 2'b00} + (2*WIDTH)'(3'd4);
    end

    case (state_r)
      S_IDLE, S_ERR: begin
        if (go) begin
          n_nxt    = num;
          d_nxt    = WIDTH'(2'd2);
          d_sq_nxt = (2*WIDTH)'(3'd4);
`ifdef PRIME_FACTORIZER_MULT_EN
          mcnt_nxt = {(WIDTH_LOG+1){1'b0}};
`endif
          if (num == {WIDTH{1'b0}}) begin
            state_nxt = S_ERR;
          end else if (num == WIDTH'(1'b1)) begin
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_CHECK;
          end
        end else begin
          state_nxt = state_r;
        end
      end
      S_CHECK: begin
        if (d_sq_r > {{WIDTH{1'b0}}, n_r}) begin
          state_nxt = S_LAST;
        end else begin
          q_nxt     = n_r;
          r_nxt     = {WIDTH{1'b0}};
          cnt_nxt   = {(WIDTH_LOG+1){1'b0}};
          state_nxt = S_DIV;
        end
      end
      S_DIV: begin
        if (!diff_s[WIDTH]) begin
          r_nxt = diff_s[WIDTH-1:0];
          q_nxt = {q_r[WIDTH-2:0], 1'b1};
        end else begin
          r_nxt = rem_shift_s[WIDTH-1:0];
          q_nxt = {q_r[WIDTH-2:0], 1'b0};
        end
        cnt_nxt = cnt_r + (WIDTH_LOG+1)'(1'b1);
        if (cnt_r == (WIDTH_LOG+1)'(WIDTH-1)) begin
          state_nxt = S_RESULT;
        end else begin
          state_nxt = S_DIV;
        end
      end
      S_RESULT: begin
`ifdef PRIME_FACTORIZER_MULT_EN
        if (r_r == {WIDTH{1'b0}}) begin
          n_nxt     = q_r;
          mcnt_nxt  = mcnt_r + (WIDTH_LOG+1)'(1'b1);
          state_nxt = S_CHECK;
        end else if (mcnt_r != {(WIDTH_LOG+1){1'b0}}) begin
          // d is exhausted: report it with its count while moving on to the next divisor.
          factor_nxt       = d_r;
          mult_nxt         = mcnt_r;
          factor_valid_nxt = 1'b1;
          mcnt_nxt         = {(WIDTH_LOG+1){1'b0}};
          d_nxt            = d_adv_s;
          d_sq_nxt         = d_sq_adv_s;
          state_nxt        = S_EMIT;
        end else begin
          d_nxt     = d_adv_s;
          d_sq_nxt  = d_sq_adv_s;
          state_nxt = S_CHECK;
        end
`else
        if (r_r == {WIDTH{1'b0}}) begin
          factor_nxt       = d_r;
          factor_valid_nxt = 1'b1;
          n_nxt            = q_r;
          state_nxt        = S_EMIT;
        end else begin
          d_nxt     = d_adv_s;
          d_sq_nxt  = d_sq_adv_s;
          state_nxt = S_CHECK;
        end
`endif
      end
      S_EMIT: begin
        if (factor_ack) begin
          factor_valid_nxt = 1'b0;
          state_nxt        = S_CHECK;
        end else begin
          state_nxt = S_EMIT;
        end
      end
      S_LAST: begin
`ifdef PRIME_FACTORIZER_MULT_EN
        if (mcnt_r != {(WIDTH_LOG+1){1'b0}}) begin
          // Flush the pending divisor first; a cofactor equal to d folds into its count.
          factor_nxt       = d_r;
          factor_valid_nxt = 1'b1;
          mcnt_nxt         = {(WIDTH_LOG+1){1'b0}};
          if (n_r == d_r) begin
            mult_nxt = mcnt_r + (WIDTH_LOG+1)'(1'b1);
            n_nxt    = WIDTH'(1'b1);
          end else begin
            mult_nxt = mcnt_r;
          end
          state_nxt = S_EMIT;
        end else if (n_r > WIDTH'(1'b1)) begin
          factor_nxt       = n_r;
          mult_nxt         = (WIDTH_LOG+1)'(1'b1);
          factor_valid_nxt = 1'b1;
          state_nxt        = S_LAST_ACK;
        end else begin
          state_nxt = S_IDLE;
        end
`else
        if (n_r > WIDTH'(1'b1)) begin
          factor_nxt       = n_r;
          factor_valid_nxt = 1'b1;
          state_nxt        = S_LAST_ACK;
        end else begin
          state_nxt = S_IDLE;
        end
`endif
      end
      S_LAST_ACK: begin
        if (factor_ack) begin
          factor_valid_nxt = 1'b0;
          state_nxt        = S_IDLE;
        end else begin
          state_nxt = S_LAST_ACK;
        end
      end
      default: begin
        factor_valid_nxt = 1'b0;
        state_nxt        = S_IDLE;
      end
    endcase

    ready_nxt = (state_nxt == S_IDLE) || (state_nxt == S_ERR);
    error_nxt = (state_nxt == S_ERR);
  end

  // State, datapath and output registers; reset aborts any job in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= S_IDLE;
      n_r            <= {WIDTH{1'b0}};
      d_r            <= {WIDTH{1'b0}};
      d_sq_r         <= {(2*WIDTH){1'b0}};
      q_r            <= {WIDTH{1'b0}};
      r_r            <= {WIDTH{1'b0}};
      cnt_r          <= {(WIDTH_LOG+1){1'b0}};
      factor_r       <= {WIDTH{1'b0}};
      factor_valid_r <= 1'b0;
      ready_r        <= 1'b1;
      error_r        <= 1'b0;
`ifdef PRIME_FACTORIZER_MULT_EN
      mult_r         <= {(WIDTH_LOG+1){1'b0}};
      mcnt_r         <= {(WIDTH_LOG+1){1'b0}};
`endif
    end else begin
      state_r        <= state_nxt;
      n_r            <= n_nxt;
      d_r            <= d_nxt;
      d_sq_r         <= d_sq_nxt;
      q_r            <= q_nxt;
      r_r            <= r_nxt;
      cnt_r          <= cnt_nxt;
      factor_r       <= factor_nxt;
      factor_valid_r <= factor_valid_nxt;
      ready_r        <= ready_nxt;
      error_r        <= error_nxt;
`ifdef PRIME_FACTORIZER_MULT_EN
      mult_r         <= mult_nxt;
      mcnt_r         <= mcnt_nxt;
`endif
    end
  end

endmodule
